// File: rtl/fifo_pkg.sv
// Shared helpers and status types for the stream FIFO family.
package fifo_pkg;

    localparam int unsigned STATUS_CNT_W = 16;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic                    almost_full;
        logic                    almost_empty;
        logic [STATUS_CNT_W-1:0] count;
    } fifo_status_t;

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port.
module fifo_sdp_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                      i_clk,
    input  logic                      i_wr_en,
    input  logic [ptr_w(DEPTH)-1:0]   i_wr_addr,
    input  logic [DATA_WIDTH-1:0]     i_wr_data,
    input  logic [ptr_w(DEPTH)-1:0]   i_rd_addr,
    output logic [DATA_WIDTH-1:0]     o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO with count, almost flags and flush.
// Optional sticky overflow/underflow outputs when STREAM_FIFO_ERR_FLAGS_EN is defined.
module stream_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      flush,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      almost_full,
    output logic                      almost_empty
`ifdef STREAM_FIFO_ERR_FLAGS_EN
    ,
    output logic                      overflow,
    output logic                      underflow
`endif
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [PW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_count, w_count_next;
    logic [DATA_WIDTH-1:0] r_out_data, w_mem_rdata;
    logic                  r_out_valid, r_af, r_ae;
    logic                  w_in_ready, w_wr, w_rd, w_bypass, w_mem_wr, w_mem_rd;

    assign w_in_ready = (r_count < DEPTH_C) && !rst_in;

    always_comb begin
        w_wr     = in_valid && w_in_ready;
        w_rd     = r_out_valid && out_ready;
        // Straight into the head register when the array holds nothing behind the head.
        w_bypass = w_wr && ((r_count == '0) || (w_rd && (r_count == ONE_C)));
        w_mem_wr = w_wr && !w_bypass && !flush;
        w_mem_rd = w_rd && (r_count > ONE_C);
        w_count_next = r_count;
        if (flush) begin
            w_count_next = '0;
        end else if (w_wr && !w_rd) begin
            w_count_next = r_count + ONE_C;
        end else if (w_rd && !w_wr) begin
            w_count_next = r_count - ONE_C;
        end
    end

    fifo_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .i_clk      (clk_in),
        .i_wr_en    (w_mem_wr),
        .i_wr_addr  (r_wptr),
        .i_wr_data  (in_data),
        .i_rd_addr  (r_rptr),
        .o_rd_data  (w_mem_rdata)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in || flush) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_af        <= 1'b0;
            r_ae        <= 1'b1;
        end else begin
            if (w_mem_wr) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_mem_rd) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_bypass) begin
                r_out_data  <= in_data;
                r_out_valid <= 1'b1;
            end else if (w_mem_rd) begin
                r_out_data  <= w_mem_rdata;
                r_out_valid <= 1'b1;
            end else if (w_rd) begin
                r_out_valid <= 1'b0;
            end
            r_count <= w_count_next;
            r_af    <= (w_count_next >= AF_C);
            r_ae    <= (w_count_next <= AE_C);
        end
    end

`ifdef STREAM_FIFO_ERR_FLAGS_EN
    logic r_overflow, r_underflow;

    // Sticky until reset; flush deliberately leaves them alone.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (in_valid && (r_count == DEPTH_C)) begin
                r_overflow <= 1'b1;
            end
            if (out_ready && !r_out_valid) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

    assign in_ready     = w_in_ready;
    assign out_data     = r_out_data;
    assign out_valid    = r_out_valid;
    assign count        = r_count;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;

endmodule
